// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - registered N-channel mux with manual select and dwell-timed auto scan
// Optional SKIP_MASK_EN: auto scan visits only channels whose mask bit is set.
module mux_scan_n #(
  parameter int WIDTH = 10,
  parameter int SEL_W = 3,
  parameter int DWELL = 4,
  localparam int CH = 2 ** SEL_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel_in,
  input  logic [CH*WIDTH-1:0] data_in,
  input  logic [CH-1:0]       mask,
  output logic [WIDTH-1:0]    data_out,
  output logic [SEL_W-1:0]    sel_out,
  output logic [CH-1:0]       strobe_n,
  output logic                valid,
  output logic                wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] TOP = SEL_W'(CH - 1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t             state, state_d;
  logic [SEL_W-1:0]   ptr, ptr_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               pend, pend_d;
  logic [WIDTH-1:0]   data_d;
  logic [SEL_W-1:0]   sel_d;
  logic [CH-1:0]      strobe_d;
  logic               valid_d, wrap_d;

  logic               entering, any, adv_wrap, adj_wrap;
  logic [SEL_W-1:0]   base, cur, adv;
  logic [CNT_W-1:0]   base_cnt;
  logic [WIDTH-1:0]   ch_data [CH];

  for (genvar k = 0; k < CH; k++) begin : g_unpack
    assign ch_data[k] = data_in[k*WIDTH +: WIDTH];
  end

`ifdef SKIP_MASK_EN
  // First set mask bit strictly after p, circularly; returns p itself if only p is set.
  function automatic logic [SEL_W-1:0] next_set(input logic [SEL_W-1:0] p,
                                                input logic [CH-1:0] m);
    logic [SEL_W-1:0] r, idx;
    logic found;
    r = p;
    found = 1'b0;
    for (int i = 1; i <= CH; i++) begin
      idx = p + SEL_W'(i);
      if (!found && m[idx]) begin
        r = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction
`else
  logic unused_mask;
  assign unused_mask = ^mask;
`endif

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    cnt_d    = cnt;
    pend_d   = pend;
    data_d   = data_out;
    sel_d    = sel_out;
    valid_d  = 1'b0;
    strobe_d = '1;
    wrap_d   = 1'b0;
    entering = 1'b0;
    any      = 1'b1;
    base     = '0;
    base_cnt = '0;
    cur      = '0;
    adv      = '0;
    adv_wrap = 1'b0;
    adj_wrap = 1'b0;

    if (en) begin
      if (!mode) begin
        state_d  = MANUAL;
        ptr_d    = '0;
        cnt_d    = '0;
        pend_d   = 1'b0;
        data_d   = ch_data[sel_in];
        sel_d    = sel_in;
        valid_d  = 1'b1;
        strobe_d = ~(CH'(1) << sel_in);
      end else begin
        state_d  = SCAN;
        entering = (state == MANUAL);
        base     = entering ? '0 : ptr;
        base_cnt = entering ? '0 : cnt;
`ifdef SKIP_MASK_EN
        any      = |mask;
        cur      = mask[base] ? base : next_set(base, mask);
        adj_wrap = !mask[base] && (cur < base);
        adv      = next_set(cur, mask);
        adv_wrap = (adv <= cur);
`else
        cur      = base;
        adv      = cur + 1'b1;
        adv_wrap = (cur == TOP);
`endif
        if (!any) begin
          // Nothing to scan: park the pointer and keep the last captured data.
          ptr_d = base;
          cnt_d = base_cnt;
        end else begin
          data_d   = ch_data[cur];
          sel_d    = cur;
          valid_d  = 1'b1;
          strobe_d = ~(CH'(1) << cur);
          wrap_d   = (pend && !entering) || adj_wrap;
          if (base_cnt == LAST) begin
            cnt_d  = '0;
            ptr_d  = adv;
            pend_d = adv_wrap;
          end else begin
            cnt_d  = base_cnt + 1'b1;
            ptr_d  = cur;
            pend_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MANUAL;
      ptr      <= '0;
      cnt      <= '0;
      pend     <= 1'b0;
      data_out <= '0;
      sel_out  <= '0;
      strobe_n <= '1;
      valid    <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      cnt      <= cnt_d;
      pend     <= pend_d;
      data_out <= data_d;
      sel_out  <= sel_d;
      strobe_n <= strobe_d;
      valid    <= valid_d;
      wrap     <= wrap_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - directed self-checking bench for mux_scan_n (DWELL=4 and DWELL=1 instances)
module tb_mux_scan_n;

  logic        clk = 1'b0;
  logic        reset, en, mode;
  logic [2:0]  sel_in;
  logic [79:0] data_in;
  logic [7:0]  mask;
  logic [9:0]  data_out, d1_data;
  logic [2:0]  sel_out, d1_sel;
  logic [7:0]  strobe_n, d1_strobe;
  logic        valid, wrap, d1_valid, d1_wrap;

  logic [9:0]  chv [8];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_scan_n #(.WIDTH(10), .SEL_W(3), .DWELL(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel_in(sel_in),
    .data_in(data_in), .mask(mask), .data_out(data_out), .sel_out(sel_out),
    .strobe_n(strobe_n), .valid(valid), .wrap(wrap)
  );

  mux_scan_n #(.WIDTH(10), .SEL_W(3), .DWELL(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel_in(sel_in),
    .data_in(data_in), .mask(mask), .data_out(d1_data), .sel_out(d1_sel),
    .strobe_n(d1_strobe), .valid(d1_valid), .wrap(d1_wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_data();
    for (int k = 0; k < 8; k++) data_in[k*10 +: 10] = chv[k];
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; mode = 1'b1; sel_in = 3'd4;
    tick(); tick();
    tests++; if (data_out !== 10'h000) begin fails++; $display("FAIL reset_data: got %h want 000", data_out); end
    tests++; if (sel_out !== 3'd0) begin fails++; $display("FAIL reset_sel: got %0d want 0", sel_out); end
    tests++; if (strobe_n !== 8'hFF) begin fails++; $display("FAIL reset_strobe: got %h want ff", strobe_n); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap: got %b want 0", wrap); end
  endtask

  task automatic test_manual();
    reset = 1'b0; mode = 1'b0; en = 1'b1; sel_in = 3'd5;
    tick();
    tests++; if (data_out !== 10'h2A5) begin fails++; $display("FAIL man_data: got %h want 2a5", data_out); end
    tests++; if (sel_out !== 3'd5) begin fails++; $display("FAIL man_sel: got %0d want 5", sel_out); end
    tests++; if (strobe_n !== 8'hDF) begin fails++; $display("FAIL man_strobe: got %h want df", strobe_n); end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL man_valid: got %b want 1", valid); end
    // data change must not show until the next edge
    chv[5] = 10'h15A; pack_data(); #2;
    tests++; if (data_out !== 10'h2A5) begin fails++; $display("FAIL man_hold_pre_edge: got %h want 2a5", data_out); end
    tick();
    tests++; if (data_out !== 10'h15A) begin fails++; $display("FAIL man_latency: got %h want 15a", data_out); end
    chv[5] = 10'h2A5; pack_data();
    sel_in = 3'd7;
    tick();
    tests++; if (data_out !== chv[7] || strobe_n !== 8'h7F) begin fails++; $display("FAIL man_ch7: got %h/%h want %h/7f", data_out, strobe_n, chv[7]); end
    sel_in = 3'd0;
    tick();
    tests++; if (data_out !== chv[0] || strobe_n !== 8'hFE || sel_out !== 3'd0) begin fails++; $display("FAIL man_ch0: got %h/%h/%0d want %h/fe/0", data_out, strobe_n, sel_out, chv[0]); end
  endtask

  task automatic test_scan();
    logic [2:0] es;
    logic       ew;
    mode = 1'b1;
    for (int i = 0; i < 33; i++) begin
      tick();
      es = 3'((i / 4) % 8);
      ew = (i == 32);
      tests++;
      if (sel_out !== es || data_out !== chv[es] || valid !== 1'b1 || wrap !== ew || strobe_n !== ~(8'h01 << es)) begin
        fails++;
        $display("FAIL scan_cycle%0d: got sel=%0d data=%h v=%b w=%b s=%h want sel=%0d data=%h v=1 w=%b", i, sel_out, data_out, valid, wrap, strobe_n, es, chv[es], ew);
      end
    end
  endtask

  task automatic test_en_gap();
    tick(); tick();
    tests++; if (sel_out !== 3'd0 || valid !== 1'b1 || wrap !== 1'b0) begin fails++; $display("FAIL gap_pre: got sel=%0d v=%b w=%b want 0/1/0", sel_out, valid, wrap); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (valid !== 1'b0 || strobe_n !== 8'hFF || sel_out !== 3'd0 || data_out !== chv[0] || wrap !== 1'b0) begin
        fails++;
        $display("FAIL gap_hold%0d: got v=%b s=%h sel=%0d data=%h w=%b want 0/ff/0/%h/0", i, valid, strobe_n, sel_out, data_out, wrap, chv[0]);
      end
    end
    en = 1'b1;
    tick();
    tests++; if (sel_out !== 3'd0 || valid !== 1'b1 || strobe_n !== 8'hFE) begin fails++; $display("FAIL gap_resume: got sel=%0d v=%b s=%h want 0/1/fe", sel_out, valid, strobe_n); end
    tick();
    tests++; if (sel_out !== 3'd1 || data_out !== chv[1]) begin fails++; $display("FAIL gap_advance: got sel=%0d data=%h want 1/%h", sel_out, data_out, chv[1]); end
  endtask

  task automatic test_reset_mid_scan();
    logic [2:0] es;
    for (int i = 0; i < 20; i++) tick();
    tests++; if (sel_out !== 3'd6) begin fails++; $display("FAIL mid_reach6: got %0d want 6", sel_out); end
    reset = 1'b1;
    tick();
    tests++; if (sel_out !== 3'd0 || valid !== 1'b0 || strobe_n !== 8'hFF || data_out !== 10'h000) begin fails++; $display("FAIL mid_reset: got sel=%0d v=%b s=%h data=%h want 0/0/ff/000", sel_out, valid, strobe_n, data_out); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      es = (i < 4) ? 3'd0 : 3'd1;
      tests++;
      if (sel_out !== es || valid !== 1'b1 || wrap !== 1'b0) begin
        fails++;
        $display("FAIL mid_restart%0d: got sel=%0d v=%b w=%b want %0d/1/0", i, sel_out, valid, wrap, es);
      end
    end
  endtask

  task automatic test_switch_manual();
    mode = 1'b0; sel_in = 3'd3;
    tick();
    tests++; if (sel_out !== 3'd3 || data_out !== chv[3] || valid !== 1'b1 || strobe_n !== 8'hF7) begin fails++; $display("FAIL sw_manual: got sel=%0d data=%h s=%h want 3/%h/f7", sel_out, data_out, strobe_n, chv[3]); end
    mode = 1'b1;
    tick();
    tests++; if (sel_out !== 3'd0 || data_out !== chv[0] || wrap !== 1'b0) begin fails++; $display("FAIL sw_rescan: got sel=%0d data=%h w=%b want 0/%h/0", sel_out, data_out, wrap, chv[0]); end
  endtask

  task automatic test_dwell1_mask();
    logic [2:0] seq [9];
    int         n;
    int         wi;
    reset = 1'b1; en = 1'b1; mode = 1'b1;
    tick();
    reset = 1'b0; mask = 8'b1000_0101;
`ifdef SKIP_MASK_EN
    seq[0] = 3'd0; seq[1] = 3'd2; seq[2] = 3'd7; seq[3] = 3'd0;
    n = 4; wi = 3;
`else
    for (int i = 0; i < 9; i++) seq[i] = 3'(i % 8);
    n = 9; wi = 8;
`endif
    for (int i = 0; i < n; i++) begin
      tick();
      tests++;
      if (d1_sel !== seq[i] || d1_valid !== 1'b1 || d1_wrap !== (i == wi) || d1_data !== chv[seq[i]]) begin
        fails++;
        $display("FAIL d1_seq%0d: got sel=%0d v=%b w=%b want sel=%0d v=1 w=%b", i, d1_sel, d1_valid, d1_wrap, seq[i], (i == wi));
      end
    end
`ifdef SKIP_MASK_EN
    mask = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (d1_valid !== 1'b0 || d1_strobe !== 8'hFF || d1_wrap !== 1'b0) begin
        fails++;
        $display("FAIL d1_mask0_%0d: got v=%b s=%h w=%b want 0/ff/0", i, d1_valid, d1_strobe, d1_wrap);
      end
    end
`endif
    mask = 8'hFF;
  endtask

  initial begin
    chv[0] = 10'h011; chv[1] = 10'h122; chv[2] = 10'h233; chv[3] = 10'h344;
    chv[4] = 10'h055; chv[5] = 10'h2A5; chv[6] = 10'h3C6; chv[7] = 10'h1D7;
    reset = 1'b1; en = 1'b0; mode = 1'b0; sel_in = 3'd0; mask = 8'hFF;
    pack_data();
    test_reset();
    test_manual();
    test_scan();
    test_en_gap();
    test_reset_mid_scan();
    test_switch_manual();
    test_dwell1_mask();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_scan_n.md
MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 SHALL have parameter WIDTH, default 10, data bits per channel.
REQ-002 SHALL have parameter SEL_W, default 3, select width; channel count CH = 2**SEL_W.
REQ-003 SHALL have parameter DWELL, default 4, cycles spent per channel in auto mode (DWELL >= 1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port en  input  1  enables capture and scanning.
REQ-007 SHALL have port mode  input  1  0 = manual select, 1 = auto scan.
REQ-008 SHALL have port sel_in  input  SEL_W  manual channel select.
REQ-009 SHALL have port data_in  input  CH*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port mask  input  CH  per-channel scan enable; used only under SKIP_MASK_EN.
REQ-011 SHALL have port data_out  output  WIDTH  registered selected channel data.
REQ-012 SHALL have port sel_out  output  SEL_W  channel index that data_out came from.
REQ-013 SHALL have port strobe_n  output  CH  active-low one-hot decode of sel_out, qualified by valid.
REQ-014 SHALL have port valid  output  1  data_out, sel_out and strobe_n were updated this cycle.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse on auto-scan pointer wrap.

Function
REQ-016 SHALL register all outputs; latency from data_in/sel_in to data_out is exactly 1 cycle.
REQ-017 SHALL, when en=0, hold data_out and sel_out, drive valid=0 and wrap=0, drive strobe_n all ones, and freeze pointer and dwell counter.
REQ-018 SHALL, in manual mode with en=1, load data_out = channel sel_in, sel_out = sel_in, and valid=1 every cycle.
REQ-019 SHALL implement the FSM states MANUAL and SCAN; the state follows mode on each enabled cycle; entering SCAN clears the pointer and dwell counter to 0 in that cycle.
REQ-020 SHALL, in SCAN with en=1, load data_out/sel_out from the pointer channel and assert valid=1 every cycle.
REQ-021 SHALL count dwell cycles 0..DWELL-1; on the cycle at count DWELL-1, the counter returns to 0 and the pointer advances by one on the next edge.
REQ-022 SHALL wrap the pointer from CH-1 to 0 and assert wrap=1 for exactly the one cycle in which sel_out first shows the wrapped value.
REQ-023 SHALL drive strobe_n[k]=0 only when valid=1 and sel_out=k; all other bits are 1.
REQ-024 SHALL, on a SCAN->MANUAL switch, clear the pointer and dwell counter; the manual capture takes effect in the same cycle.
REQ-025 SHALL treat DWELL=1 as advancing the pointer every cycle.

Reset
REQ-026 SHALL, on a clock edge with reset=1, drive data_out=0, sel_out=0, strobe_n all ones, valid=0, wrap=0, pointer=0, dwell counter=0, and state=MANUAL.
REQ-027 SHALL give reset priority over en and mode; reset mid-scan abandons the dwell, and scanning restarts from channel 0.

Configuration
REQ-028 SHALL, with SKIP_MASK_EN defined, advance the pointer to the next channel (circular) whose mask bit is 1, and assert wrap when that advance passes through index CH-1 -> 0.
REQ-029 SHALL, with SKIP_MASK_EN defined and mask all zero in SCAN, hold the pointer, drive valid=0, strobe_n all ones, and hold data_out; SCAN entry with the pointer on a masked channel advances to the next unmasked channel before the first valid output.
REQ-030 SHALL, without SKIP_MASK_EN, ignore mask and visit all CH channels in order.

Verification
REQ-031 SHALL verify reset: hold reset=1 with en=1 and mode=1 -> data_out=0, sel_out=0, strobe_n=8'hFF, valid=0.
REQ-032 SHALL verify manual mode: WIDTH=10, channel 5 = 10'h2A5, sel_in=5, en=1 -> next cycle data_out=10'h2A5, sel_out=5, strobe_n=8'hDF, valid=1.
REQ-033 SHALL verify auto scan: mode=1, DWELL=4 -> sel_out is 0 for 4 cycles, then 1 for 4 cycles, ... up to 7, then 0 with wrap=1 for exactly one cycle (33rd valid cycle).
REQ-034 SHALL verify the en gap: drop en for 3 cycles mid-dwell at count 2 -> outputs held, valid=0, strobe_n=8'hFF; resume -> 1 more cycle on the same channel, then advance.
REQ-035 SHALL verify the mask (SKIP_MASK_EN): mask=8'b1000_0101, DWELL=1 -> sel_out sequence 0,2,7,0 with wrap on the second 0; mask=0 -> valid stays 0.
REQ-036 SHALL verify reset mid-scan: assert reset for 1 cycle while sel_out=6 -> after release in mode=1, sel_out restarts at 0 with a full DWELL count.
